// File: rtl/corr_dump_capture_if.sv
// Bus between tracking_channel/firmware and the dump capture block.
// slave is the capture block's view; master is the driver/reader side.
interface corr_dump_capture_if #(
  parameter int CNT_W = 16
);
  logic               enable;
  logic               dump;
  logic signed [15:0] i_early;
  logic signed [15:0] q_early;
  logic signed [15:0] i_prompt;
  logic signed [15:0] q_prompt;
  logic signed [15:0] i_late;
  logic signed [15:0] q_late;
  logic               rd_ack;
  logic               clr_status;
  logic signed [15:0] ie_o;
  logic signed [15:0] qe_o;
  logic signed [15:0] ip_o;
  logic signed [15:0] qp_o;
  logic signed [15:0] il_o;
  logic signed [15:0] ql_o;
  logic [31:0]        pow_e;
  logic [31:0]        pow_p;
  logic [31:0]        pow_l;
  logic               valid;
  logic               busy;
  logic               corr_ok;
  logic [CNT_W-1:0]   dump_count;
  logic               overrun;
  logic               dump_missed;

  modport slave (
    input  enable, dump, i_early, q_early, i_prompt, q_prompt, i_late, q_late,
    input  rd_ack, clr_status,
    output ie_o, qe_o, ip_o, qp_o, il_o, ql_o, pow_e, pow_p, pow_l,
    output valid, busy, corr_ok, dump_count, overrun, dump_missed
  );

  modport master (
    output enable, dump, i_early, q_early, i_prompt, q_prompt, i_late, q_late,
    output rd_ack, clr_status,
    input  ie_o, qe_o, ip_o, qp_o, il_o, ql_o, pow_e, pow_p, pow_l,
    input  valid, busy, corr_ok, dump_count, overrun, dump_missed
  );
endinterface

// File: rtl/corr_dump_capture.sv
// Snapshots E/P/L I/Q on a dump and computes I^2+Q^2 powers with one shared multiplier.
// Snapshot visible 1 cycle after dump, powers/valid 6 cycles after; dumps while busy are dropped.
module corr_dump_capture #(
  parameter logic [31:0] MIN_PROMPT_POW = 32'd1000,
  parameter int          CNT_W          = 16
) (
  input  logic               clk,
  input  logic               rstn,
  corr_dump_capture_if.slave bus
);

  typedef enum logic {IDLE, CALC} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [2:0]         idx;
  logic [31:0]        acc;
  logic [31:0]        stage_e;
  logic [31:0]        stage_p;
  logic signed [15:0] ie, qe, ip, qp, il, ql;
  logic [31:0]        pow_e, pow_p, pow_l;
  logic               valid;
  logic               corr_ok;
  logic               overrun;
  logic               dump_missed;
  logic [CNT_W-1:0]   dump_count;

  logic               busy;
  logic               accept;
  logic               missed;
  logic               finish;
  logic signed [15:0] op;
  logic signed [31:0] op_ext;
  logic [31:0]        sq;
  logic [31:0]        sum;
  logic               corr_new;

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    accept    = 1'b0;
    missed    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.enable && bus.dump) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        busy   = 1'b1;
        missed = bus.enable && bus.dump;
        if (idx == 3'd5) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand order IE, QE, IP, QP, IL, QL; odd idx closes a pair.
  always_comb begin
    op = ie;
    case (idx)
      3'd0:    op = ie;
      3'd1:    op = qe;
      3'd2:    op = ip;
      3'd3:    op = qp;
      3'd4:    op = il;
      3'd5:    op = ql;
      default: op = ie;
    endcase
  end

  assign op_ext   = 32'(op);
  assign sq       = op_ext * op_ext;
  assign sum      = acc + sq;
  assign corr_new = (stage_p >= MIN_PROMPT_POW) && (stage_p >= stage_e) && (stage_p >= sum);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      idx         <= '0;
      acc         <= '0;
      stage_e     <= '0;
      stage_p     <= '0;
      ie          <= '0;
      qe          <= '0;
      ip          <= '0;
      qp          <= '0;
      il          <= '0;
      ql          <= '0;
      pow_e       <= '0;
      pow_p       <= '0;
      pow_l       <= '0;
      valid       <= 1'b0;
      corr_ok     <= 1'b0;
      overrun     <= 1'b0;
      dump_missed <= 1'b0;
      dump_count  <= '0;
    end else begin
      if (accept) begin
        ie         <= bus.i_early;
        qe         <= bus.q_early;
        ip         <= bus.i_prompt;
        qp         <= bus.q_prompt;
        il         <= bus.i_late;
        ql         <= bus.q_late;
        dump_count <= dump_count + {{(CNT_W-1){1'b0}}, 1'b1};
        idx        <= '0;
        acc        <= '0;
      end

      if (state == CALC) begin
        idx <= idx + 3'd1;
        if (idx[0]) begin
          acc <= '0;
          if (idx == 3'd1)      stage_e <= sum;
          else if (idx == 3'd3) stage_p <= sum;
        end else begin
          acc <= sum;
        end
      end

      // Completion beats a coincident rd_ack.
      if (finish) begin
        pow_e   <= stage_e;
        pow_p   <= stage_p;
        pow_l   <= sum;
        corr_ok <= corr_new;
        valid   <= 1'b1;
      end else if (bus.rd_ack) begin
        valid <= 1'b0;
      end

      if (accept && valid)     overrun <= 1'b1;
      else if (bus.clr_status) overrun <= 1'b0;

      if (missed)              dump_missed <= 1'b1;
      else if (bus.clr_status) dump_missed <= 1'b0;
    end
  end

  assign bus.ie_o        = ie;
  assign bus.qe_o        = qe;
  assign bus.ip_o        = ip;
  assign bus.qp_o        = qp;
  assign bus.il_o        = il;
  assign bus.ql_o        = ql;
  assign bus.pow_e       = pow_e;
  assign bus.pow_p       = pow_p;
  assign bus.pow_l       = pow_l;
  assign bus.valid       = valid;
  assign bus.busy        = busy;
  assign bus.corr_ok     = corr_ok;
  assign bus.dump_count  = dump_count;
  assign bus.overrun     = overrun;
  assign bus.dump_missed = dump_missed;

endmodule

// File: tb/tb_corr_dump_capture.sv
// Bench for corr_dump_capture: vector table, corner sequences and random traffic vs a cycle model.
// A second instance with a 3-bit counter shares the stimulus so counter wrap is exercised.
module tb_corr_dump_capture;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  corr_dump_capture_if #(.CNT_W(16)) bus ();
  corr_dump_capture_if #(.CNT_W(3))  bus_w ();

  corr_dump_capture #(.MIN_PROMPT_POW(32'd1000), .CNT_W(16)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  corr_dump_capture #(.MIN_PROMPT_POW(32'd1000), .CNT_W(3)) dut_w (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_w)
  );

  assign bus_w.enable     = bus.enable;
  assign bus_w.dump       = bus.dump;
  assign bus_w.i_early    = bus.i_early;
  assign bus_w.q_early    = bus.q_early;
  assign bus_w.i_prompt   = bus.i_prompt;
  assign bus_w.q_prompt   = bus.q_prompt;
  assign bus_w.i_late     = bus.i_late;
  assign bus_w.q_late     = bus.q_late;
  assign bus_w.rd_ack     = bus.rd_ack;
  assign bus_w.clr_status = bus.clr_status;

  int checks = 0;
  int errors = 0;

  // Reference model: an accepted dump at edge k completes at edge k+6; any dump
  // before then is refused.
  int     m_snap[6];
  longint m_pe, m_pp, m_pl;
  bit     m_valid, m_ok, m_ovr, m_miss, m_pend;
  int     m_cnt;
  int     n, m_done_at;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit in_calc, comp, take;
    n++;
    if (!rstn) begin
      foreach (m_snap[i]) m_snap[i] = 0;
      m_pe = 0; m_pp = 0; m_pl = 0;
      m_valid = 0; m_ok = 0; m_ovr = 0; m_miss = 0; m_pend = 0; m_cnt = 0;
      return;
    end
    in_calc = m_pend;
    comp    = m_pend && (n == m_done_at);
    take    = bus.enable && bus.dump && !in_calc;
    if (bus.enable && bus.dump && in_calc) m_miss = 1;
    else if (bus.clr_status)               m_miss = 0;
    if (take && m_valid)     m_ovr = 1;
    else if (bus.clr_status) m_ovr = 0;
    if (take) begin
      m_snap[0] = int'(bus.i_early);  m_snap[1] = int'(bus.q_early);
      m_snap[2] = int'(bus.i_prompt); m_snap[3] = int'(bus.q_prompt);
      m_snap[4] = int'(bus.i_late);   m_snap[5] = int'(bus.q_late);
      m_cnt++;
      m_pend = 1;
      m_done_at = n + 6;
    end
    if (comp) begin
      m_pe = longint'(m_snap[0]) * m_snap[0] + longint'(m_snap[1]) * m_snap[1];
      m_pp = longint'(m_snap[2]) * m_snap[2] + longint'(m_snap[3]) * m_snap[3];
      m_pl = longint'(m_snap[4]) * m_snap[4] + longint'(m_snap[5]) * m_snap[5];
      m_ok = (m_pp >= 1000) && (m_pp >= m_pe) && (m_pp >= m_pl);
      m_valid = 1;
      m_pend = 0;
    end else if (bus.rd_ack) begin
      m_valid = 0;
    end
  endtask

  task automatic compare_all();
    chk("ie_o", longint'(bus.ie_o), m_snap[0]);
    chk("qe_o", longint'(bus.qe_o), m_snap[1]);
    chk("ip_o", longint'(bus.ip_o), m_snap[2]);
    chk("qp_o", longint'(bus.qp_o), m_snap[3]);
    chk("il_o", longint'(bus.il_o), m_snap[4]);
    chk("ql_o", longint'(bus.ql_o), m_snap[5]);
    chk("pow_e", longint'(bus.pow_e), m_pe);
    chk("pow_p", longint'(bus.pow_p), m_pp);
    chk("pow_l", longint'(bus.pow_l), m_pl);
    chk("valid", longint'(bus.valid), longint'(m_valid));
    chk("busy", longint'(bus.busy), longint'(m_pend));
    chk("corr_ok", longint'(bus.corr_ok), longint'(m_ok));
    chk("overrun", longint'(bus.overrun), longint'(m_ovr));
    chk("dump_missed", longint'(bus.dump_missed), longint'(m_miss));
    chk("dump_count", longint'(bus.dump_count), longint'(m_cnt % 65536));
    chk("dump_count_w3", longint'(bus_w.dump_count), longint'(m_cnt % 8));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic set_iq(input int a, input int b, input int c, input int d, input int e, input int f);
    bus.i_early  = 16'(a);
    bus.q_early  = 16'(b);
    bus.i_prompt = 16'(c);
    bus.q_prompt = 16'(d);
    bus.i_late   = 16'(e);
    bus.q_late   = 16'(f);
  endtask

  task automatic pulse_dump();
    bus.dump = 1'b1;
    step();
    bus.dump = 1'b0;
  endtask

  task automatic ack();
    bus.rd_ack = 1'b1;
    step();
    bus.rd_ack = 1'b0;
  endtask

  function automatic int rnd16();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 5))
      0:       return -32768;
      1:       return 32767;
      2:       return int'($signed(r)) / 256;
      default: return int'($signed(r));
    endcase
  endfunction

  typedef struct {
    int     ie, qe, ip, qp, il, ql;
    longint pe, pp, pl;
    bit     ok;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{3, -4, 100, -50, -7, 0, 25, 12500, 49, 1'b1};
    tbl[1] = '{-32768, -32768, -32768, -32768, -32768, -32768, 64'h8000_0000, 64'h8000_0000, 64'h8000_0000, 1'b1};
    tbl[2] = '{0, 0, 10, 10, 0, 0, 0, 200, 0, 1'b0};
    tbl[3] = '{1000, 0, 0, 0, 0, 0, 1000000, 0, 0, 1'b0};
    tbl[4] = '{0, 0, 32767, -32768, 0, 0, 0, 2147418113, 0, 1'b1};
    tbl[5] = '{20, 20, 31, 0, 0, 0, 800, 961, 0, 1'b0};
    tbl[6] = '{0, 0, 30, 10, 0, 31, 0, 1000, 961, 1'b1};
    tbl[7] = '{0, 0, 40, 0, 0, -41, 0, 1600, 1681, 1'b0};

    n = 0; m_done_at = 0;
    rstn = 1'b0;
    bus.enable = 1'b0; bus.dump = 1'b0; bus.rd_ack = 1'b0; bus.clr_status = 1'b0;
    set_iq(0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("rst_valid", longint'(bus.valid), 0);
    chk("rst_busy", longint'(bus.busy), 0);
    chk("rst_count", longint'(bus.dump_count), 0);
    chk("rst_pow_p", longint'(bus.pow_p), 0);
    rstn = 1'b1;
    bus.enable = 1'b1;
    step();

    // Table vectors, each acknowledged before the next.
    for (int i = 0; i < 8; i++) begin
      set_iq(tbl[i].ie, tbl[i].qe, tbl[i].ip, tbl[i].qp, tbl[i].il, tbl[i].ql);
      pulse_dump();
      chk("tbl_count", longint'(bus.dump_count), i + 1);
      chk("tbl_ip_o", longint'(bus.ip_o), tbl[i].ip);
      repeat (5) step();
      chk("tbl_busy_k6", longint'(bus.busy), 1);
      chk("tbl_valid_early", longint'(bus.valid), 0);
      step();
      chk("tbl_busy_done", longint'(bus.busy), 0);
      chk("tbl_valid", longint'(bus.valid), 1);
      chk("tbl_pow_e", longint'(bus.pow_e), tbl[i].pe);
      chk("tbl_pow_p", longint'(bus.pow_p), tbl[i].pp);
      chk("tbl_pow_l", longint'(bus.pow_l), tbl[i].pl);
      chk("tbl_corr_ok", longint'(bus.corr_ok), longint'(tbl[i].ok));
      ack();
      chk("tbl_ack_valid", longint'(bus.valid), 0);
      chk("tbl_ack_corr_ok", longint'(bus.corr_ok), longint'(tbl[i].ok));
    end

    // Overrun: weak result left unacknowledged, then a new dump.
    set_iq(0, 0, 10, 10, 0, 0);
    pulse_dump();
    repeat (6) step();
    chk("weak_pow_p", longint'(bus.pow_p), 200);
    chk("weak_corr_ok", longint'(bus.corr_ok), 0);
    set_iq(3, -4, 100, -50, -7, 0);
    pulse_dump();
    chk("ovr_flag", longint'(bus.overrun), 1);
    chk("ovr_new_snap", longint'(bus.ip_o), 100);
    chk("ovr_old_pow", longint'(bus.pow_p), 200);
    repeat (5) step();
    chk("ovr_valid_held", longint'(bus.valid), 1);
    chk("ovr_pow_still_old", longint'(bus.pow_p), 200);
    step();
    chk("ovr_new_pow", longint'(bus.pow_p), 12500);
    bus.clr_status = 1'b1;
    step();
    bus.clr_status = 1'b0;
    chk("ovr_cleared", longint'(bus.overrun), 0);
    ack();

    // Dump while busy is dropped.
    pulse_dump();
    step();
    step();
    set_iq(-32768, -32768, -32768, -32768, -32768, -32768);
    pulse_dump();
    chk("miss_flag", longint'(bus.dump_missed), 1);
    chk("miss_count", longint'(bus.dump_count), 11);
    chk("miss_snap", longint'(bus.ip_o), 100);
    repeat (3) step();
    chk("miss_pow_p", longint'(bus.pow_p), 12500);
    bus.enable = 1'b0;
    pulse_dump();
    chk("dis_count", longint'(bus.dump_count), 11);
    chk("dis_busy", longint'(bus.busy), 0);
    chk("dis_snap", longint'(bus.ie_o), 3);
    bus.enable = 1'b1;
    bus.clr_status = 1'b1;
    step();
    bus.clr_status = 1'b0;
    chk("miss_cleared", longint'(bus.dump_missed), 0);
    ack();

    // rd_ack on the completion edge loses; one cycle later it clears.
    set_iq(3, -4, 100, -50, -7, 0);
    pulse_dump();
    repeat (5) step();
    bus.rd_ack = 1'b1;
    step();
    chk("coll_valid", longint'(bus.valid), 1);
    step();
    bus.rd_ack = 1'b0;
    chk("coll_valid_late", longint'(bus.valid), 0);

    // Reset at k+3 aborts, then a clean computation.
    pulse_dump();
    step();
    step();
    rstn = 1'b0;
    step();
    chk("mrst_busy", longint'(bus.busy), 0);
    chk("mrst_valid", longint'(bus.valid), 0);
    chk("mrst_count", longint'(bus.dump_count), 0);
    chk("mrst_ie_o", longint'(bus.ie_o), 0);
    chk("mrst_pow_p", longint'(bus.pow_p), 0);
    rstn = 1'b1;
    step();
    pulse_dump();
    repeat (6) step();
    chk("mrst_pow_e", longint'(bus.pow_e), 25);
    chk("mrst_pow_p2", longint'(bus.pow_p), 12500);
    chk("mrst_pow_l", longint'(bus.pow_l), 49);
    chk("mrst_count2", longint'(bus.dump_count), 1);
    chk("mrst_ok", longint'(bus.corr_ok), 1);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rstn           = ($urandom_range(0, 599) != 0);
      bus.enable     = ($urandom_range(0, 7) != 0);
      bus.dump       = ($urandom_range(0, 3) == 0);
      bus.rd_ack     = ($urandom_range(0, 5) == 0);
      bus.clr_status = ($urandom_range(0, 15) == 0);
      set_iq(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
